mux_collect_83_lxy: RTL

//   Round-robin 8-to-1 data collector: the gather side of the 3-8 decoder/distributor.

---
 rtl/mux_collect_83_lxy_if.sv | 13 +
 rtl/mux_collect_83_lxy.sv | 63 ++++++
 2 files changed

// File: rtl/mux_collect_83_lxy_if.sv
// mux_collect_83_lxy_if: request/data/ack bundle for the 8-to-1 collector plus its valid/ready output
interface mux_collect_83_lxy_if #(parameter int DATA_W = 4);
    logic              en;
    logic [7:0]        req_n;
    logic [DATA_W-1:0] data_in [8];
    logic [7:0]        ack_n;
    logic [2:0]        sel;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;
    modport master (output en, req_n, data_in, ready, input ack_n, sel, data_out, valid);
    modport slave  (input en, req_n, data_in, ready, output ack_n, sel, data_out, valid);
endinterface

// File: rtl/mux_collect_83_lxy.sv
// mux_collect_83_lxy: round-robin 8-to-1 collector with valid/ready output and per-channel ack pulse
module mux_collect_83_lxy #(
    parameter int DATA_W = 4
) (
    input logic                 sys_clk,
    input logic                 sys_rst_n,
    mux_collect_83_lxy_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [2:0]        sel_q;
    logic [2:0]        grant_d;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        ack_n_q;
    logic [7:0]        elig_d;
    logic              valid_q;
    logic              found_d;
    logic              take_d;

    assign bus.ack_n    = ack_n_q;
    assign bus.sel      = sel_q;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;

    // rotating first-fit search from ptr; a channel still being acked is masked so it is not taken twice
    always_comb begin
        elig_d  = ~bus.req_n & ack_n_q;
        found_d = 1'b0;
        grant_d = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found_d && elig_d[ptr_q + 3'(i)]) begin
                found_d = 1'b1;
                grant_d = ptr_q + 3'(i);
            end
        end
        take_d = bus.en && found_d && (state_q == IDLE || bus.ready);
    end

    // capture on grant (back-to-back from HOLD when ready), otherwise release after handshake
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sel_q   <= 3'd0;
            data_q  <= '0;
            ack_n_q <= 8'hFF;
            ptr_q   <= 3'd0;
        end else begin
            ack_n_q <= take_d ? ~(8'b1 << grant_d) : 8'hFF;
            if (take_d) begin
                state_q <= HOLD;
                valid_q <= 1'b1;
                sel_q   <= grant_d;
                data_q  <= bus.data_in[grant_d];
                ptr_q   <= grant_d + 3'd1;
            end else if (state_q == HOLD && bus.ready) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end
        end
    end
endmodule
